// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : cpu_ctrl_pkg                                       |
// | Description : Shared state encoding, instruction field positions |
// |               and opcode constants for the CPU control FSM.      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package cpu_ctrl_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  // Instruction word field positions
  localparam int c_OPCODE_HI = 15;
  localparam int c_OPCODE_LO = 12;
  localparam int c_RDEST_HI  = 11;
  localparam int c_RDEST_LO  = 8;
  localparam int c_OPEXT_HI  = 7;
  localparam int c_OPEXT_LO  = 4;
  localparam int c_RSRC_HI   = 3;
  localparam int c_RSRC_LO   = 0;

  // Opcode / opext constants
  localparam logic [3:0] c_OP_REG    = 4'b0000;  // register-register class
  localparam logic [3:0] c_OP_CMP    = 4'b1011;  // immediate compare
  localparam logic [3:0] c_OPEXT_CMP = 4'b1011;  // register compare (with c_OP_REG)

  // A compare is either the register form (opcode 0000, opext 1011) or opcode 1011
  function automatic logic isCmp(input logic [15:0] ir);
    logic [3:0] opcode;
    logic [3:0] opext;
    opcode = ir[c_OPCODE_HI:c_OPCODE_LO];
    opext  = ir[c_OPEXT_HI:c_OPEXT_LO];
    return ((opcode == c_OP_REG) && (opext == c_OPEXT_CMP)) || (opcode == c_OP_CMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_decode_4to16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : onehot_decode_4to16                                |
// | Description : 4-to-16 one-hot decoder with enable; all outputs   |
// |               are zero while the enable is low.                  |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module onehot_decode_4to16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  // One comparator per output bit
  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign onehot[i] = en && (sel == 4'(i));
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cpu_control_fsm                                    |
// | Description : Four-state instruction controller (IDLE, DECODE,   |
// |               EXECUTE, WRITEBACK). Latches one instruction per   |
// |               4-cycle issue slot, drives datapath mux selects,   |
// |               a one-hot register write enable in WRITEBACK, a    |
// |               retire pulse and a wrapping retire counter.        |
// |               Optional macro CPU_CTRL_CMP_NOWB_EN: suppress the  |
// |               register write for compare instructions.           |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module cpu_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] RegEnable,
  output logic [3:0]  MuxControlA,
  output logic [3:0]  MuxControlB,
  output logic        MuxControlC,
  output logic [15:0] AluControl,
  output logic        done,
  output logic [15:0] retired_count
);

  import cpu_ctrl_pkg::*;

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_ir;
  logic [15:0] r_retiredCount;
  logic        w_accept;
  logic        w_inWriteback;
  logic        w_wbEnable;

  assign w_accept      = (r_state == ST_IDLE) && instr_valid;
  assign w_inWriteback = (r_state == ST_WRITEBACK);

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: wait for a valid word in IDLE, then walk the fixed pipeline
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:      w_stateNext = w_accept ? ST_DECODE : ST_IDLE;
      ST_DECODE:    w_stateNext = ST_EXECUTE;
      ST_EXECUTE:   w_stateNext = ST_WRITEBACK;
      ST_WRITEBACK: w_stateNext = ST_IDLE;
      default:      w_stateNext = ST_IDLE;
    endcase
  end

  // Instruction register: loads only on accept, so mux selects hold until the next issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= 16'h0000;
    end else if (w_accept) begin
      r_ir <= instr;
    end
  end

  // Retire counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retiredCount <= 16'h0000;
    end else if (w_inWriteback) begin
      r_retiredCount <= r_retiredCount + 16'd1;
    end
  end

`ifdef CPU_CTRL_CMP_NOWB_EN
  // Compares only set flags in the ALU, so their register write is dropped
  assign w_wbEnable = w_inWriteback && !isCmp(r_ir);
`else
  assign w_wbEnable = w_inWriteback;
`endif

  onehot_decode_4to16 u_regDecode (
    .sel    (r_ir[c_RDEST_HI:c_RDEST_LO]),
    .en     (w_wbEnable),
    .onehot (RegEnable)
  );

  assign instr_ready   = (r_state == ST_IDLE);
  assign done          = w_inWriteback;
  assign MuxControlA   = r_ir[c_RDEST_HI:c_RDEST_LO];
  assign MuxControlB   = r_ir[c_RSRC_HI:c_RSRC_LO];
  assign MuxControlC   = (r_ir[c_OPCODE_HI:c_OPCODE_LO] != c_OP_REG);
  assign AluControl    = r_ir;
  assign retired_count = r_retiredCount;

endmodule
`default_nettype wire
